// File: rtl/bit_entry_conditioner.sv
// Enter-key conditioner: synchronises and debounces the button and data switch,
// emitting one strobed serial bit per clean press for the sequence detector.
module bit_entry_conditioner #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int CNT_W           = 18,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_raw,
    input  logic               sw_raw,
    output logic               bit_out,
    output logic               bit_valid,
    output logic [COUNT_W-1:0] bit_count,
    output logic               btn_held
);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    // With a one-cycle window the counter stays at 0 so it never exceeds its terminal value.
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FIRST = (DEBOUNCE_CYCLES > 1) ? CNT_W'(1) : '0;

    logic               btn_meta_q, btn_meta_d;
    logic               btn_s_q,    btn_s_d;
    logic               sw_meta_q,  sw_meta_d;
    logic               sw_s_q,     sw_s_d;
    logic [1:0]         state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               bit_out_q,  bit_out_d;
    logic               bit_valid_q, bit_valid_d;
    logic [COUNT_W-1:0] bit_count_q, bit_count_d;
    logic               btn_held_q, btn_held_d;

    always_comb begin
        btn_meta_d  = btn_raw;
        btn_s_d     = btn_meta_q;
        sw_meta_d   = sw_raw;
        sw_s_d      = sw_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        bit_count_d = bit_count_q;

        case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_FIRST;
                end else begin
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    bit_valid_d = 1'b1;
                    bit_out_d   = sw_s_q;
                    bit_count_d = bit_count_q + COUNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_FIRST;
                end else begin
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Held indication covers the release debounce window too, dropping only on IDLE.
        btn_held_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_meta_q  <= 1'b0;
            btn_s_q     <= 1'b0;
            sw_meta_q   <= 1'b0;
            sw_s_q      <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_out_q   <= 1'b1;
            bit_valid_q <= 1'b0;
            bit_count_q <= '0;
            btn_held_q  <= 1'b0;
        end else begin
            btn_meta_q  <= btn_meta_d;
            btn_s_q     <= btn_s_d;
            sw_meta_q   <= sw_meta_d;
            sw_s_q      <= sw_s_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            bit_count_q <= bit_count_d;
            btn_held_q  <= btn_held_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign bit_count = bit_count_q;
    assign btn_held  = btn_held_q;

endmodule

// File: doc/bit_entry_conditioner.md
Name: bit_entry_conditioner

Overview:
- Upstream input stage for the board-level sequence detector.
- Takes a raw push-button (the "enter" key) and a raw data slide switch, synchronises and debounces both, and on each clean press emits exactly one serial bit (the switch value) with a one-cycle strobe.
- Holds the entered bit stable between presses so the slow-clocked detector FSM samples a clean x.
- Also exposes an entered-bit counter for display/debug.

Parameters:
- DEBOUNCE_CYCLES, 240000, consecutive stable clk cycles required to accept a press or release (~20 ms at 12 MHz); sims use 4.
- CNT_W, 18, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- COUNT_W, 8, width of bit_count.

Ports:
- clk  input  1  system clock (Sys_Clk0 domain).
- rst_n  input  1  synchronous, active-low reset.
- btn_raw  input  1  raw enter button, active-high, asynchronous and bouncy.
- sw_raw  input  1  raw data switch, asynchronous.
- bit_out  output  1  last entered bit; feeds detector x.
- bit_valid  output  1  one-cycle pulse when a new bit is accepted.
- bit_count  output  COUNT_W  number of bits accepted, modulo 2^COUNT_W.
- btn_held  output  1  high while a debounced press is held.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset values:
  - bit_out=1 (idle level, matches the detector's non-detect input).
  - bit_valid=0, bit_count=0, btn_held=0.
  - State=IDLE, debounce counter=0, all sync flops=0.
- Synchronisers: btn_raw and sw_raw each pass through a 2-flop synchroniser, giving btn_s and sw_s. They add 2 cycles latency. No logic is fed from the raw inputs.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: if btn_s=1, go to PRESS_WAIT with counter=1; else stay with counter=0.
  - PRESS_WAIT:
    - If btn_s=0 (bounce), go to IDLE with counter=0.
    - Else if counter==DEBOUNCE_CYCLES-1, go to HELD, with bit_valid=1 for exactly that transition cycle and bit_out<=sw_s sampled in the same cycle.
    - Else counter+1.
  - HELD: btn_held=1. If btn_s=0, go to RELEASE_WAIT with counter=1. No further bit_valid while held, however long.
  - RELEASE_WAIT:
    - If btn_s=1 (bounce), go back to HELD with counter=0.
    - Else if counter==DEBOUNCE_CYCLES-1, go to IDLE.
    - Else counter+1.
    - btn_held stays 1 until IDLE is entered.
- Latency: bit_valid rises DEBOUNCE_CYCLES clk cycles after btn_s first goes high and stays high, i.e. 2+DEBOUNCE_CYCLES cycles after a clean btn_raw edge.
- bit_valid: registered, never high on two consecutive cycles, never high in reset.
- bit_out: changes only on a bit_valid cycle. It reflects sw_s in that cycle; switch changes at other times are ignored. Stable for at least 2*DEBOUNCE_CYCLES cycles between updates.
- bit_count:
  - Increments by 1 on each bit_valid.
  - Wraps from 2^COUNT_W-1 to 0 without saturation and without a flag.
- Counter width: the debounce counter never exceeds DEBOUNCE_CYCLES-1 and is cleared on every state change not listed above.
- Reset mid-operation: rst_n=0 in any state forces the reset values on the next edge. A press in progress is discarded, with no bit_valid. After reset is released with the button still held, the press must be re-debounced from IDLE; one bit is then emitted.
- DEBOUNCE_CYCLES=1: PRESS_WAIT accepts on its first cycle if btn_s is still 1. Must be legal; no underflow.
- Simultaneous switch change and acceptance: the value in sw_s on the bit_valid cycle wins.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with btn_raw=1 and sw_raw=0 -> bit_out=1, bit_valid=0, bit_count=0, btn_held=0 throughout.
- Clean press (DEBOUNCE_CYCLES=4): sw_raw=0, btn_raw 0->1 held 20 cycles -> single bit_valid 6 cycles after the edge, bit_out=0, bit_count=1, btn_held=1 until 6 cycles after release.
- Bounce: btn_raw toggles 1,0,1,0 every 2 cycles, then held high -> no bit_valid during bounce; exactly one bit_valid 4 cycles after btn_s settles high. Release bounce produces no extra pulse.
- Sequence entry: enter 0,1,1,0 via four clean presses -> bit_out sequence 0,1,1,0 on four bit_valid pulses, bit_count=4, bit_out stable between pulses despite switch wiggles while held.
- Wrap: COUNT_W=2, six presses -> bit_count 1,2,3,0,1,2.
- Reset mid-press: assert rst_n=0 during PRESS_WAIT, release with button still high -> no pulse until a full re-debounce, then exactly one bit_valid.
